// File: rtl/shift_reg_univ_if.sv
// Control/data bundle for the universal shift register.
// The master drives the operation request; the slave returns the stored word and status.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, sin, start, amount,
    input  q, sout, busy, done
  );

  modport slave (
    input  en, mode, d, sin, start, amount,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with eight step modes, serial I/O and a
// multi-step engine that repeats one latched mode `amount` times, one step per clock.
module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  shift_reg_univ_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_ASR   = 3'b111;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [WIDTH:0]   step_res;

  // One step of the selected mode; result is {sout, q}.
  function automatic logic [WIDTH:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur_q,
    input logic             cur_sout,
    input logic             s_in,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH:0] res;
    case (m)
      MODE_HOLD:  res = {cur_sout, cur_q};
      MODE_LOAD:  res = {1'b0, ld};
      MODE_SHL:   res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], s_in};
      MODE_SHR:   res = {cur_q[0], s_in, cur_q[WIDTH-1:1]};
      MODE_ROL:   res = {cur_q[WIDTH-1], cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
      MODE_ROR:   res = {cur_q[0], cur_q[0], cur_q[WIDTH-1:1]};
      MODE_CLEAR: res = '0;
      MODE_ASR:   res = {cur_q[0], cur_q[WIDTH-1], cur_q[WIDTH-1:1]};
      default:    res = {cur_sout, cur_q};
    endcase
    return res;
  endfunction

  // The load data is captured at start so a multi-step load ignores d while busy.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    sout_d   = sout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    ld_d     = ld_q;
    step_res = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.amount != '0) begin
            mode_d  = bus.mode;
            ld_d    = bus.d;
            cnt_d   = bus.amount;
            busy_d  = 1'b1;
            state_d = BUSY;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.en) begin
          step_res       = step_fn(bus.mode, q_q, sout_q, bus.sin, bus.d);
          {sout_d, q_d}  = step_res;
        end
      end
      BUSY: begin
        step_res      = step_fn(mode_q, q_q, sout_q, bus.sin, ld_q);
        {sout_d, q_d} = step_res;
        cnt_d         = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ld_q    <= ld_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register. It is the next generation of the team's single-bit D flip-flop: the stored word is WIDTH bits, with eight operation modes, serial in/out, and a multi-step shift engine that applies one operation N times, one step per clock. It is used as the general-purpose storage and shift element in the datapath practicals (serialisers, multipliers, barrel-shift emulation).

Parameters:
WIDTH, 8, register width in bits (≥2)
RESET_VAL, 0, value loaded into q on reset
AMT_W, $clog2(WIDTH+1) (localparam), width of amount

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  single-step enable (idle only)
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin  input  1  serial input bit
start  input  1  begin multi-step operation (idle only)
amount  input  AMT_W  number of steps for start
q  output  WIDTH  register contents
sout  output  1  bit shifted/rotated out by the most recent step
busy  output  1  multi-step operation in progress
done  output  1  one-cycle pulse when a multi-step operation completes

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. While reset is high: q=RESET_VAL, sout=0, busy=0, done=0, step counter=0. This takes effect immediately, including mid-operation; the aborted operation produces no done.
- Modes (one step):
  - 000 hold: q and sout unchanged.
  - 001 load: q=d, sout=0.
  - 010 SHL: q={q[W-2:0],sin}, sout=old q[W-1].
  - 011 SHR: q={sin,q[W-1:1]}, sout=old q[0].
  - 100 ROL: q={q[W-2:0],q[W-1]}, sout=old q[W-1].
  - 101 ROR: q={q[0],q[W-1:1]}, sout=old q[0].
  - 110 clear: q=0, sout=0.
  - 111 ASR: q={q[W-1],q[W-1:1]}, sout=old q[0].
- States: IDLE, BUSY.
- IDLE:
  - start=1 has priority over en.
  - If start=1 and amount>0: latch mode and amount, busy←1, q not modified on this edge.
  - If start=1 and amount=0: done←1 for one cycle, busy stays 0, q unchanged.
  - Else if en=1: apply one step of mode at this edge. Latency is 1 cycle.
  - Else: hold.
- BUSY:
  - Each edge applies one step of the latched mode and decrements the counter.
  - On the edge where the counter goes 1→0: busy←0 and done←1 for exactly one cycle; state returns to IDLE.
  - busy is high for exactly amount cycles. done is high in the cycle after the last step.
  - en, start, mode, amount and d are ignored. sin is sampled live each step.
- done: a single-cycle pulse; otherwise 0.
- A new start in the cycle where done=1 is accepted, because the block is IDLE.
- amount may exceed WIDTH; exactly amount steps are performed (e.g. SHL by 9 with sin=0 gives 0; ROL by WIDTH returns the original value).
- sout always reflects the last step performed; it is not cleared by hold.

Test Plan:
1. WIDTH=8. Assert reset for 2 cycles, then release -> q=0x00, busy=0, done=0. Mode 001, en=1, d=0xA5 -> q=0xA5 one edge later. en=0, mode 010 -> q stays 0xA5.
2. From q=0xA5: mode 010, sin=1, en=1 for one edge -> q=0x4B, sout=1. Then mode 011, sin=0, one edge -> q=0x25, sout=1.
3. From q=0xA5: start=1, mode 101, amount=3 -> busy high 3 cycles, q steps D2→69→B4. done=1 for one cycle after the last step. Change mode and assert en during busy -> no effect.
4. q=0x80, start with mode 111, amount=8 -> q=0xFF after 8 steps, busy=8 cycles, single done pulse. q=0x81, ROL amount=8 -> q=0x81.
5. start with amount=0 -> done=1 next cycle, busy never asserted, q unchanged. start and en both high in idle -> start wins, no single step applied.
6. Load 0x3C, start SHL amount=5, assert reset asynchronously after 2 steps (between edges) -> q=0x00 and busy=0 immediately, no done. After release, en-load 0x11 works -> q=0x11.
